// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter.
// Sends one command byte to the device over the open-drain PS2_CLK/PS2_DAT pair.
// It inhibits the clock, issues request-to-send, shifts out D0..D7, odd parity
// and stop on device clock falls, then checks the device ACK.
// Optional build macro: PS2_HOST_TX_TIMEOUT_EN adds a watchdog between device
// clock events. Without it, a silent device is recovered by reset only.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 120,
  parameter int TIMEOUT_CYCLES = 15000
) (
  input  logic       i_clk_1M,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic       o_clk_oe,
  output logic       o_dat_oe,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_RTS,
    ST_DATA,
    ST_ACK,
    ST_RELEASE
  } state_t;

  state_t             r_state;
  logic [INH_W-1:0]   r_inh;
  logic [3:0]         r_idx;
  logic [7:0]         r_data;
  logic               r_par;
  logic               r_clk_oe;
  logic               r_dat_oe;
  logic               r_done;
  logic               r_err;

  logic               r_clk_s1;
  logic               r_clk_s2;
  logic               r_clk_s3;
  logic               r_dat_s1;
  logic               r_dat_s2;

  logic               w_fall;
  logic               w_timeout;
  logic [3:0]         w_next_idx;

  // Synchronize the pins; reset to the idle-high bus level so no false fall appears.
  always_ff @(posedge i_clk_1M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_s3 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= i_ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_s3 <= r_clk_s2;
      r_dat_s1 <= i_ps2_dat;
      r_dat_s2 <= r_dat_s1;
    end
  end

  assign w_fall     = r_clk_s3 & ~r_clk_s2;
  assign w_next_idx = r_idx + 4'd1;

`ifdef PS2_HOST_TX_TIMEOUT_EN
  logic        r_wd;
  logic [13:0] r_wd_cnt;
  logic        w_watch;

  assign w_watch   = (r_state == ST_RTS) || (r_state == ST_DATA) ||
                     (r_state == ST_ACK) || (r_state == ST_RELEASE);
  assign w_timeout = w_watch && (r_wd_cnt == 14'(TIMEOUT_CYCLES - 1));

  // Watchdog: every move between watched states happens on a fall, so clearing
  // on a fall also covers state entry; outside the watched states it stays at 0.
  always_ff @(posedge i_clk_1M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wd_cnt <= '0;
      r_wd     <= 1'b0;
    end else begin
      r_wd <= w_watch;
      if (!w_watch || w_fall || w_timeout) begin
        r_wd_cnt <= '0;
      end else begin
        r_wd_cnt <= r_wd_cnt + 14'd1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Latch the byte and its odd parity at acceptance; payload needs no reset.
  always_ff @(posedge i_clk_1M) begin
    if (i_valid && (r_state == ST_IDLE)) begin
      r_data <= i_data;
      r_par  <= ~^i_data;
    end
  end

  // Frame sequencer with registered line enables and status pulses.
  always_ff @(posedge i_clk_1M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_inh    <= '0;
      r_idx    <= '0;
      r_clk_oe <= 1'b0;
      r_dat_oe <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_timeout) begin
        r_state  <= ST_IDLE;
        r_clk_oe <= 1'b0;
        r_dat_oe <= 1'b0;
        r_err    <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            if (i_valid) begin
              r_state  <= ST_INHIBIT;
              r_inh    <= '0;
              r_clk_oe <= 1'b1;
            end
          end
          ST_INHIBIT: begin
            if (r_inh == INH_W'(INHIBIT_CYCLES - 1)) begin
              r_state  <= ST_START;
              r_dat_oe <= 1'b1;
            end else begin
              r_inh <= r_inh + 1'b1;
            end
          end
          ST_START: begin
            // Data stays low as the start bit; releasing the clock is the request-to-send.
            r_state  <= ST_RTS;
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b1;
          end
          ST_RTS: begin
            if (w_fall) begin
              r_state  <= ST_DATA;
              r_idx    <= 4'd0;
              r_dat_oe <= ~r_data[0];
            end
          end
          ST_DATA: begin
            if (w_fall) begin
              r_idx <= w_next_idx;
              if (w_next_idx <= 4'd7) begin
                r_dat_oe <= ~r_data[w_next_idx[2:0]];
              end else if (w_next_idx == 4'd8) begin
                r_dat_oe <= ~r_par;
              end else begin
                r_dat_oe <= 1'b0;
                r_state  <= ST_ACK;
              end
            end
          end
          ST_ACK: begin
            if (w_fall) begin
              if (r_dat_s2) begin
                r_err   <= 1'b1;
                r_state <= ST_IDLE;
              end else begin
                r_state <= ST_RELEASE;
              end
            end
          end
          ST_RELEASE: begin
            if (r_clk_s2 && r_dat_s2) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
          default: begin
            r_state  <= ST_IDLE;
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_ready  = (r_state == ST_IDLE);
  assign o_busy   = (r_state != ST_IDLE);
  assign o_clk_oe = r_clk_oe;
  assign o_dat_oe = r_dat_oe;
  assign o_done   = r_done;
  assign o_err    = r_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a simple PS/2 device model
// clocking at roughly 12 kHz (40 cycles low, 40 cycles high at 1 MHz).
`timescale 1ns/1ps
module tb_ps2_host_tx;

  logic       clk;
  logic       rst_n;
  logic       i_valid;
  logic [7:0] i_data;
  logic       o_ready;
  logic       o_clk_oe;
  logic       o_dat_oe;
  logic       o_busy;
  logic       o_done;
  logic       o_err;
  logic       dev_clk_low;
  logic       dev_dat_low;
  logic       ps2_clk;
  logic       ps2_dat;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  assign ps2_clk = ~(o_clk_oe | dev_clk_low);
  assign ps2_dat = ~(o_dat_oe | dev_dat_low);

  ps2_host_tx dut (
    .i_clk_1M (clk),
    .i_rst_n  (rst_n),
    .i_valid  (i_valid),
    .i_data   (i_data),
    .o_ready  (o_ready),
    .i_ps2_clk(ps2_clk),
    .i_ps2_dat(ps2_dat),
    .o_clk_oe (o_clk_oe),
    .o_dat_oe (o_dat_oe),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_err    (o_err)
  );

  initial clk = 1'b0;
  always #500 clk = ~clk;

  always @(negedge clk) begin
    if (o_done) done_cnt++;
    if (o_err)  err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Request a byte and measure how long the clock line is inhibited.
  task automatic request(input logic [7:0] d, output int inh);
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = d;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_data  = 8'h00;
    inh = 0;
    while (o_clk_oe && inh < 1000) begin
      @(posedge clk);
      #1;
      inh++;
    end
  endtask

  // Device side of one frame: 11 clock pulses, sample the line late in each low
  // phase, optionally ACK on the 11th, inject a request or reset mid-frame.
  task automatic frame(input logic [7:0] d, input bit ack, input int inject_k,
                       input int abort_k, output logic [9:0] bits, output int inh);
    bits = '0;
    request(d, inh);
    check("rts_dat_oe", {31'd0, o_dat_oe}, 32'd1);
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && ack) dev_dat_low = 1'b1;
      wait_cyc(40);
      dev_clk_low = 1'b1;
      wait_cyc(30);
      if (k <= 10) bits[k-1] = ps2_dat;
      if (k == inject_k) begin
        i_valid = 1'b1;
        i_data  = 8'h55;
        wait_cyc(1);
        i_valid = 1'b0;
        i_data  = 8'h00;
      end
      if (k == abort_k) begin
        check("pre_rst_dat_oe", {31'd0, o_dat_oe}, 32'd1);
        #200 rst_n = 1'b0;
        #1;
        check("rst_clk_oe_async", {31'd0, o_clk_oe}, 32'd0);
        check("rst_dat_oe_async", {31'd0, o_dat_oe}, 32'd0);
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(2);
        check("post_rst_ready", {31'd0, o_ready}, 32'd1);
        check("post_rst_busy", {31'd0, o_busy}, 32'd0);
        return;
      end
      wait_cyc(10);
      dev_clk_low = 1'b0;
    end
    dev_dat_low = 1'b0;
  endtask

  initial begin
    logic [9:0] bits;
    int inh;
    int d0;
    int e0;
    int m;

    rst_n = 1'b0;
    i_valid = 1'b0;
    i_data = 8'h00;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    wait_cyc(3);
    check("rst_ready", {31'd0, o_ready}, 32'd1);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_clk_oe", {31'd0, o_clk_oe}, 32'd0);
    check("rst_dat_oe", {31'd0, o_dat_oe}, 32'd0);
    check("rst_done", {31'd0, o_done}, 32'd0);
    check("rst_err", {31'd0, o_err}, 32'd0);
    rst_n = 1'b1;
    wait_cyc(3);

    // 0xED: D0..D7 = 1,0,1,1,0,1,1,1, parity 1, stop 1.
    d0 = done_cnt; e0 = err_cnt;
    frame(8'hED, 1'b1, 0, 0, bits, inh);
    wait_cyc(20);
    check("ed_inhibit_len", inh, 32'd121);
    check("ed_bits", {22'd0, bits}, 32'h3ED);
    check("ed_done", done_cnt - d0, 32'd1);
    check("ed_err", err_cnt - e0, 32'd0);
    check("ed_ready", {31'd0, o_ready}, 32'd1);

    // 0x07 with a stray 0x55 request during the frame: parity 0, byte unchanged.
    d0 = done_cnt; e0 = err_cnt;
    frame(8'h07, 1'b1, 3, 0, bits, inh);
    wait_cyc(20);
    check("07_bits", {22'd0, bits}, 32'h207);
    check("07_done", done_cnt - d0, 32'd1);
    check("07_err", err_cnt - e0, 32'd0);
    check("07_no_requeue", {31'd0, o_busy}, 32'd0);

    // 0xFF: parity 1.
    d0 = done_cnt; e0 = err_cnt;
    frame(8'hFF, 1'b1, 0, 0, bits, inh);
    wait_cyc(20);
    check("ff_bits", {22'd0, bits}, 32'h3FF);
    check("ff_done", done_cnt - d0, 32'd1);

    // 0xF4 with no ACK from the device.
    d0 = done_cnt; e0 = err_cnt;
    frame(8'hF4, 1'b0, 0, 0, bits, inh);
    wait_cyc(20);
    check("noack_bits", {22'd0, bits}, 32'h2F4);
    check("noack_err", err_cnt - e0, 32'd1);
    check("noack_done", done_cnt - d0, 32'd0);
    check("noack_clk_oe", {31'd0, o_clk_oe}, 32'd0);
    check("noack_dat_oe", {31'd0, o_dat_oe}, 32'd0);
    check("noack_ready", {31'd0, o_ready}, 32'd1);

    // Device never clocks after request-to-send.
    e0 = err_cnt;
    request(8'hF4, inh);
    check("silent_inhibit_len", inh, 32'd121);
`ifdef PS2_HOST_TX_TIMEOUT_EN
    m = 0;
    while (!o_err && m < 20000) begin
      @(posedge clk);
      #1;
      m++;
    end
    check("timeout_latency", m, 32'd15000);
    wait_cyc(2);
    check("timeout_err_count", err_cnt - e0, 32'd1);
    check("timeout_ready", {31'd0, o_ready}, 32'd1);
    check("timeout_dat_oe", {31'd0, o_dat_oe}, 32'd0);
`else
    m = 0;
    wait_cyc(2000);
    check("hang_busy", {31'd0, o_busy}, 32'd1);
    check("hang_dat_oe", {31'd0, o_dat_oe}, 32'd1);
    check("hang_no_err", err_cnt - e0, 32'd0);
    rst_n = 1'b0;
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(2);
    check("hang_recover_ready", {31'd0, o_ready}, 32'd1);
`endif

    // Reset while D4 of 0xED (a 0 bit, so dat_oe=1) is on the line.
    e0 = err_cnt;
    frame(8'hED, 1'b1, 0, 5, bits, inh);
    wait_cyc(5);
    check("abort_no_err", err_cnt - e0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
